aidc_lite_comp_job_sched: RTL and testbench
===========================================

AIDC_LITE_COMP_JOB_SCHED -- requirements
Module: AIDC_LITE_COMP_JOB_SCHED

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning job queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 8, meaning job tag width.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port push_valid_i  in  1  job request valid.
REQ-006 SHALL have port push_ready_o  out  1  job request accepted when high with push_valid_i.
REQ-007 SHALL have port push_src_i  in  32  source address.
REQ-008 SHALL have port push_dst_i  in  32  destination address.
REQ-009 SHALL have port push_len_i  in  25  length in 128-byte units (bits [31:7]).
REQ-010 SHALL have port push_tag_o  out  TAG_W  tag given to the job accepted this cycle.
REQ-011 SHALL have port flush_i  in  1  discard all queued (not running) jobs.
REQ-012 SHALL have ports src_addr_o/dst_addr_o  out  32 each, and len_o  out  25; engine job fields.
REQ-013 SHALL have port start_o  out  1  one-cycle engine start pulse.
REQ-014 SHALL have port done_i  in  1  one-cycle engine completion pulse.
REQ-015 SHALL have ports cmpl_valid_o  out  1, cmpl_tag_o  out  TAG_W, cmpl_skip_o  out  1; job-finished pulse, tag, zero-length flag.
REQ-016 SHALL have ports busy_o  out  1 (state != IDLE) and pending_o  out  $clog2(DEPTH+1) (queued job count).
REQ-017 SHALL have ports spurious_done_o  out  1 (sticky) and clr_err_i  in  1 (clears it).

Function
REQ-018 Queue SHALL be a FIFO; push_ready_o = !full && !flush_i; accept = push_valid_i && push_ready_o.
REQ-019 Tag counter SHALL start at 0, increment by 1 per accept, wrap 2^TAG_W-1 -> 0; push_tag_o = current counter value.
REQ-020 FSM states SHALL be IDLE, LAUNCH, WAIT.
REQ-021 IDLE with queue non-empty: pop head, latch src/dst/len/tag into output regs; len != 0 -> LAUNCH; len == 0 -> stay IDLE, pulse cmpl_valid_o with cmpl_skip_o=1 next cycle, no start_o.
REQ-022 LAUNCH SHALL assert start_o for exactly one cycle, then go WAIT.
REQ-023 WAIT on done_i SHALL pulse cmpl_valid_o next cycle with the latched tag, cmpl_skip_o=0, and return to IDLE.
REQ-024 Latency: job accepted at cycle N into an empty idle scheduler -> start_o at N+2; done_i at M -> cmpl_valid_o at M+1; next queued start_o no earlier than M+2.
REQ-025 src_addr_o/dst_addr_o/len_o SHALL hold stable from LAUNCH until the cycle after done_i.
REQ-026 done_i outside WAIT SHALL be ignored and set spurious_done_o; clr_err_i clears it; set wins over simultaneous clear.
REQ-027 flush_i SHALL empty the queue next cycle; running job unaffected; simultaneous pop in IDLE wins over flush for the head entry.
REQ-028 Push and pop in same cycle on a full queue SHALL NOT accept the push (ready based on registered full).
REQ-029 pending_o SHALL reflect accepts/pops/flush registered, range 0..DEPTH.

Reset
REQ-030 On rst: state IDLE, queue empty, tag counter 0, all outputs 0, spurious_done_o 0.
REQ-031 rst mid-job SHALL abandon the job with no cmpl_valid_o; later done_i counts as spurious.

Structure
REQ-032 Package AIDC_LITE_COMP_PKG SHALL hold the job descriptor struct (src, dst, len, tag), FSM state enum, and LEN_W=25.
REQ-033 Queue SHALL be sub-module AIDC_LITE_COMP_JOB_FIFO (DEPTH x descriptor, registered full/empty, flush).

Verification
REQ-034 Single job src=0x1000,dst=0x2000,len=4 pushed at N -> start_o at N+2 with those fields; done_i at N+10 -> cmpl_valid_o, tag 0 at N+11.
REQ-035 Push 5 jobs back-to-back with DEPTH=4, engine stalled -> 5th push blocked until first pop; pending_o peaks at 4; completions in order, tags 0..4.
REQ-036 Push len=0 job -> no start_o; cmpl_valid_o with cmpl_skip_o=1, two cycles after push.
REQ-037 3 jobs queued, one running, flush_i -> pending_o=0; running job completes; no further start_o.
REQ-038 done_i in IDLE -> spurious_done_o=1 until clr_err_i; FSM unchanged.
REQ-039 256 jobs -> tag wraps 255 -> 0; rst during WAIT -> all outputs 0, no completion.

Source files
------------

// File: rtl/aidc_lite_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_comp_pkg
// Description : Shared types for the compression-engine job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package aidc_lite_comp_pkg;

    localparam int LEN_W     = 25;
    // Descriptor tag field is sized for the widest supported TAG_W.
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic [31:0]          src;
        logic [31:0]          dst;
        logic [LEN_W-1:0]     len;
        logic [TAG_MAX_W-1:0] tag;
    } job_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/aidc_lite_comp_job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_comp_job_fifo
// Description : DEPTH-entry job descriptor FIFO with registered flags and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module aidc_lite_comp_job_fifo
    import aidc_lite_comp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  job_desc_t                  push_desc,
    input  logic                       pop,
    input  logic                       flush,
    output job_desc_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    job_desc_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_full;
    logic               r_empty;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_CNT_W-1:0] w_count_nxt;

    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    // A pop in the flush cycle still consumes the head; everything behind it goes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_desc;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/aidc_lite_comp_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_comp_job_sched
// Description : Queues compression jobs, launches them on the engine, reports completions.
// Revision    : 1.0 - initial release
// ============================================================================
module aidc_lite_comp_job_sched
    import aidc_lite_comp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [31:0]                push_src_i,
    input  logic [31:0]                push_dst_i,
    input  logic [LEN_W-1:0]           push_len_i,
    output logic [TAG_W-1:0]           push_tag_o,
    input  logic                       flush_i,
    output logic [31:0]                src_addr_o,
    output logic [31:0]                dst_addr_o,
    output logic [LEN_W-1:0]           len_o,
    output logic                       start_o,
    input  logic                       done_i,
    output logic                       cmpl_valid_o,
    output logic [TAG_W-1:0]           cmpl_tag_o,
    output logic                       cmpl_skip_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       spurious_done_o,
    input  logic                       clr_err_i
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;

    logic [TAG_W-1:0] r_tag_cnt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [TAG_W-1:0] r_job_tag;
    logic             r_cmpl_valid;
    logic             r_cmpl_skip;
    logic             r_spurious;

    job_desc_t        w_push_desc;
    job_desc_t        w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_accept;
    logic             w_pop;
    logic             w_head_zero;
    logic             w_unused_tag;

    // Nothing is accepted while reset is held, so every output reads 0 in reset.
    assign push_ready_o = !rst && !w_fifo_full && !flush_i;
    assign w_accept     = push_valid_i && push_ready_o;
    assign w_pop        = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_head_zero  = (w_head.len == '0);
    assign w_unused_tag = ^w_head.tag;

    always_comb begin
        w_push_desc     = '0;
        w_push_desc.src = push_src_i;
        w_push_desc.dst = push_dst_i;
        w_push_desc.len = push_len_i;
        w_push_desc.tag = TAG_MAX_W'(r_tag_cnt);
    end

    aidc_lite_comp_job_fifo #(
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_desc (w_push_desc),
        .pop       (w_pop),
        .flush     (flush_i),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (pending_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_pop && !w_head_zero) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT:   if (done_i) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_cnt    <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_job_tag    <= '0;
            r_cmpl_valid <= 1'b0;
            r_cmpl_skip  <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag_cnt <= r_tag_cnt + TAG_W'(1);
            end
            // Job fields stay frozen until the next pop, covering the whole engine run.
            if (w_pop) begin
                r_src     <= w_head.src;
                r_dst     <= w_head.dst;
                r_len     <= w_head.len;
                r_job_tag <= w_head.tag[TAG_W-1:0];
            end
            r_cmpl_valid <= (w_pop && w_head_zero) || ((r_state == ST_WAIT) && done_i);
            r_cmpl_skip  <= w_pop && w_head_zero;
            if (done_i && (r_state != ST_WAIT)) begin
                r_spurious <= 1'b1;
            end else if (clr_err_i) begin
                r_spurious <= 1'b0;
            end
        end
    end

    assign push_tag_o      = r_tag_cnt;
    assign src_addr_o      = r_src;
    assign dst_addr_o      = r_dst;
    assign len_o           = r_len;
    assign start_o         = (r_state == ST_LAUNCH);
    assign busy_o          = (r_state != ST_IDLE);
    assign cmpl_valid_o    = r_cmpl_valid;
    assign cmpl_tag_o      = r_job_tag;
    assign cmpl_skip_o     = r_cmpl_skip;
    assign spurious_done_o = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_aidc_lite_comp_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aidc_lite_comp_job_sched
// Description : Directed and randomized self-checking bench for the job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aidc_lite_comp_job_sched;

    localparam int DEPTH = 4;
    localparam int TAG_W = 8;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid_i;
    logic              push_ready_o;
    logic [31:0]       push_src_i;
    logic [31:0]       push_dst_i;
    logic [24:0]       push_len_i;
    logic [TAG_W-1:0]  push_tag_o;
    logic              flush_i;
    logic [31:0]       src_addr_o;
    logic [31:0]       dst_addr_o;
    logic [24:0]       len_o;
    logic              start_o;
    logic              done_i;
    logic              cmpl_valid_o;
    logic [TAG_W-1:0]  cmpl_tag_o;
    logic              cmpl_skip_o;
    logic              busy_o;
    logic [CNT_W-1:0]  pending_o;
    logic              spurious_done_o;
    logic              clr_err_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aidc_lite_comp_job_sched #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .push_valid_i    (push_valid_i),
        .push_ready_o    (push_ready_o),
        .push_src_i      (push_src_i),
        .push_dst_i      (push_dst_i),
        .push_len_i      (push_len_i),
        .push_tag_o      (push_tag_o),
        .flush_i         (flush_i),
        .src_addr_o      (src_addr_o),
        .dst_addr_o      (dst_addr_o),
        .len_o           (len_o),
        .start_o         (start_o),
        .done_i          (done_i),
        .cmpl_valid_o    (cmpl_valid_o),
        .cmpl_tag_o      (cmpl_tag_o),
        .cmpl_skip_o     (cmpl_skip_o),
        .busy_o          (busy_o),
        .pending_o       (pending_o),
        .spurious_done_o (spurious_done_o),
        .clr_err_i       (clr_err_i)
    );

    // Reference model: a job queue plus the engine's view of the current job.
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [24:0] len;
        logic [7:0]  tag;
    } job_t;

    job_t       q[$];
    job_t       cur;
    int         tag_cnt;
    bit         launch_due;
    bit         running;
    bit         m_cv;
    bit         m_skip;
    bit         m_spur;
    logic [7:0] m_ctag;

    function automatic bit m_ready();
        return !rst && (q.size() < DEPTH) && !flush_i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit   acc;
        job_t j;
        acc = push_valid_i && m_ready();
        if (rst) begin
            q.delete();
            cur        = '{default: '0};
            tag_cnt    = 0;
            launch_due = 0;
            running    = 0;
            m_cv       = 0;
            m_skip     = 0;
            m_spur     = 0;
            return;
        end
        m_cv   = 0;
        m_skip = 0;
        if (done_i && !running) m_spur = 1;
        else if (clr_err_i) m_spur = 0;
        if (running && done_i) begin
            m_cv    = 1;
            m_ctag  = cur.tag;
            running = 0;
        end else if (launch_due) begin
            launch_due = 0;
            running    = 1;
        end else if (!running && q.size() > 0) begin
            cur = q.pop_front();
            if (cur.len == 0) begin
                m_cv   = 1;
                m_skip = 1;
                m_ctag = cur.tag;
            end else begin
                launch_due = 1;
            end
        end
        if (flush_i) q.delete();
        if (acc) begin
            j = '{push_src_i, push_dst_i, push_len_i, 8'(tag_cnt)};
            q.push_back(j);
            tag_cnt = (tag_cnt + 1) % 256;
        end
    endtask

    task automatic check_all();
        chk("push_ready", push_ready_o, m_ready());
        chk("push_tag", push_tag_o, tag_cnt);
        chk("pending", pending_o, q.size());
        chk("start", start_o, launch_due);
        chk("busy", busy_o, launch_due || running);
        chk("cmpl_valid", cmpl_valid_o, m_cv);
        chk("spurious", spurious_done_o, m_spur);
        if (m_cv) begin
            chk("cmpl_tag", cmpl_tag_o, m_ctag);
            chk("cmpl_skip", cmpl_skip_o, m_skip);
        end
        if (launch_due || running || (m_cv && !m_skip)) begin
            chk("src_addr", src_addr_o, cur.src);
            chk("dst_addr", dst_addr_o, cur.dst);
            chk("len", len_o, cur.len);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive_job(input logic v, input logic [31:0] s, input logic [31:0] d,
                             input logic [24:0] l);
        push_valid_i = v;
        push_src_i   = s;
        push_dst_i   = d;
        push_len_i   = l;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush_i   = 1'b0;
        done_i    = 1'b0;
        clr_err_i = 1'b0;
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        step();
        step();
        chk("rst_src", src_addr_o, 0);
        chk("rst_dst", dst_addr_o, 0);
        chk("rst_len", len_o, 0);
        chk("rst_ready", push_ready_o, 0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        int k;
        int ncmpl;
        int accepts;
        bit acc;

        do_reset();

        // Single job: start two cycles after accept, completion one cycle after done.
        chk("idle_ready", push_ready_o, 1);
        drive_job(1'b1, 32'h1000, 32'h2000, 25'd4);
        step();
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        chk("single_n1_start", start_o, 0);
        step();
        chk("single_n2_start", start_o, 1);
        chk("single_n2_src", src_addr_o, 32'h1000);
        chk("single_n2_dst", dst_addr_o, 32'h2000);
        chk("single_n2_len", len_o, 4);
        for (int i = 0; i < 8; i++) step();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("single_cmpl_valid", cmpl_valid_o, 1);
        chk("single_cmpl_tag", cmpl_tag_o, 0);
        chk("single_cmpl_skip", cmpl_skip_o, 0);
        step();
        chk("single_idle", busy_o, 0);

        // Back-to-back pushes with a stalled engine fill the queue and block.
        do_reset();
        k = 0;
        ncmpl = 0;
        for (int c = 0; c < 120 && ncmpl < 6; c++) begin
            drive_job(k < 6, 32'h100 * (k + 1), 32'h8000 + k, 25'(k + 1));
            done_i = (c >= 12) && running;
            acc = push_valid_i && m_ready();
            step();
            if (acc) k++;
            if (m_cv) begin
                chk("order_tag", cmpl_tag_o, ncmpl);
                ncmpl++;
            end
            if (c == 10) begin
                chk("peak_pending", pending_o, 4);
                chk("full_blocks", push_ready_o, 0);
            end
        end
        chk("all_completed", ncmpl, 6);
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        done_i = 1'b0;
        step();

        // Zero-length job: no start, skip completion two cycles after push.
        drive_job(1'b1, 32'hAAAA, 32'hBBBB, 25'd0);
        step();
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        chk("skip_n1_start", start_o, 0);
        step();
        chk("skip_cmpl_valid", cmpl_valid_o, 1);
        chk("skip_cmpl_flag", cmpl_skip_o, 1);
        chk("skip_n2_start", start_o, 0);
        step();

        // Flush with three queued and one running.
        for (int i = 0; i < 4; i++) begin
            drive_job(1'b1, 32'h4000 + i, 32'h5000 + i, 25'd7);
            step();
        end
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        chk("preflush_pending", pending_o, 3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_pending", pending_o, 0);
        chk("flush_running", busy_o, 1);
        step();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("flush_cmpl", cmpl_valid_o, 1);
        for (int i = 0; i < 5; i++) step();
        chk("flush_no_more", busy_o, 0);

        // Spurious done while idle; set wins over a simultaneous clear.
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("spur_set", spurious_done_o, 1);
        chk("spur_fsm_idle", busy_o, 0);
        step();
        done_i    = 1'b1;
        clr_err_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("spur_set_wins", spurious_done_o, 1);
        step();
        clr_err_i = 1'b0;
        chk("spur_cleared", spurious_done_o, 0);

        // Tag counter wraps after 256 accepts.
        do_reset();
        accepts = 0;
        for (int c = 0; c < 275; c++) begin
            drive_job(accepts < 258, 32'(c), 32'(c * 3), 25'd0);
            acc = push_valid_i && m_ready();
            step();
            if (acc) begin
                accepts++;
                if (accepts == 256) chk("tag_wrap", push_tag_o, 0);
            end
        end
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        chk("wrap_accepts", accepts, 258);

        // Reset during WAIT abandons the job; the later done is spurious.
        drive_job(1'b1, 32'hC000, 32'hD000, 25'd5);
        step();
        drive_job(1'b0, 32'h0, 32'h0, 25'h0);
        step();
        step();
        chk("wait_busy", busy_o, 1);
        rst = 1'b1;
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_src_mid", src_addr_o, 0);
        rst = 1'b0;
        step();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("rst_no_cmpl", cmpl_valid_o, 0);
        chk("rst_late_done_spur", spurious_done_o, 1);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            drive_job(($urandom % 10) < 6, $urandom(), $urandom(),
                      ($urandom % 4 == 0) ? 25'd0 : 25'($urandom()));
            done_i    = running ? ($urandom % 3 == 0) : ($urandom % 50 == 0);
            flush_i   = ($urandom % 33 == 0);
            clr_err_i = ($urandom % 20 == 0);
            rst       = ($urandom % 500 == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
